// File: rtl/alu_arbiter.sv
// alu_arbiter: two valid/ready request channels sharing one combinational ALU.
// Define ALU_ARB_RR_EN for round-robin ties; default gives req0 fixed priority.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_out,
  output logic [2:0]  resp0_nzv,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_out,
  output logic [2:0]  resp1_nzv,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_nf,
  input  logic        alu_zf,
  input  logic        alu_vf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        owner_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic [2:0]  nzv_q;
  logic [1:0]  rv_q;
  logic        gnt;
  logic        idle;
  logic        acc;
  logic        own_rdy;

`ifdef ALU_ARB_RR_EN
  logic last_q;

  // On a tie the requester not served last wins.
  always_comb begin
    gnt = ~req0_valid;
    if (req0_valid && req1_valid)
      gnt = ~last_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      last_q <= 1'b1;
    else if (acc)
      last_q <= gnt;
  end
`else
  always_comb gnt = ~req0_valid;
`endif

  assign idle       = (state_q == IDLE);
  assign req0_ready = idle && req0_valid && !gnt;
  assign req1_ready = idle && req1_valid && gnt;
  assign acc        = req0_ready || req1_ready;
  assign own_rdy    = owner_q ? resp1_ready : resp0_ready;

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign busy   = !idle;

  assign resp0_valid = rv_q[0];
  assign resp1_valid = rv_q[1];
  assign resp0_out   = rv_q[0] ? res_q : '0;
  assign resp0_nzv   = rv_q[0] ? nzv_q : '0;
  assign resp1_out   = rv_q[1] ? res_q : '0;
  assign resp1_nzv   = rv_q[1] ? nzv_q : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      nzv_q   <= '0;
      rv_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            owner_q <= gnt;
            op_q    <= gnt ? req1_op : req0_op;
            a_q     <= gnt ? req1_a : req0_a;
            b_q     <= gnt ? req1_b : req0_b;
            cnt_q   <= CNT_INIT;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            res_q   <= alu_out;
            nzv_q   <= {alu_nf, alu_zf, alu_vf};
            rv_q    <= owner_q ? 2'b10 : 2'b01;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (own_rdy) begin
            rv_q    <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table plus scoreboard bench for alu_arbiter.
// Grant expectations follow ALU_ARB_RR_EN when it is defined.
module tb_alu_arbiter;

  localparam int EC = 3;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp0_out, resp1_out;
  logic [2:0]  resp0_nzv, resp1_nzv;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_nf, alu_zf, alu_vf;
  logic        busy;

  alu_arbiter #(.EXEC_CYCLES(EC)) u_dut (
    .CLK(clk), .nRST(nrst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_out(resp0_out), .resp0_nzv(resp0_nzv),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_out(resp1_out), .resp1_nzv(resp1_nzv),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_nf(alu_nf), .alu_zf(alu_zf),
    .alu_vf(alu_vf), .busy(busy)
  );

  // Model of the shared combinational ALU.
  always_comb begin
    alu_out = '0;
    alu_vf  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_out = alu_a + alu_b;
        alu_vf  = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_out = alu_a - alu_b;
        alu_vf  = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      OP_AND: alu_out = alu_a & alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
    alu_nf = alu_out[31];
    alu_zf = (alu_out == '0);
  end

  typedef struct {
    logic        ch;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic [2:0]  nzv;
  } vec_t;

  typedef struct {
    logic        ch;
    logic [31:0] out;
    logic [2:0]  nzv;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic        gl[$];
  logic [31:0] exp_out[2];
  logic [2:0]  exp_nzv[2];
  logic        seen_r1 = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  vec_t        vt[9];

  task automatic chk(string nm, logic [199:0] act, logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Scoreboard: push on accept, compare on response rise, pop on handshake.
  initial begin
    logic [1:0]  pv;
    logic [1:0]  rv;
    logic [1:0]  rr;
    logic [31:0] ro[2];
    logic [2:0]  rn[2];
    logic [31:0] po[2];
    logic [2:0]  pn[2];
    exp_t        e;
    pv = '0;
    forever begin
      @(negedge clk);
      rv = {resp1_valid, resp0_valid};
      rr = {resp1_ready, resp0_ready};
      ro[0] = resp0_out; ro[1] = resp1_out;
      rn[0] = resp0_nzv; rn[1] = resp1_nzv;
      if (!nrst) begin
        pv = '0;
        continue;
      end
      if (busy)
        chk("ready_while_busy", {req1_ready, req0_ready}, 0);
      if (req0_ready || req1_ready)
        chk("ready_onehot", req0_ready && req1_ready, 0);
      if (req1_ready)
        seen_r1 = 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (c == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
          e.ch  = c[0];
          e.out = exp_out[c];
          e.nzv = exp_nzv[c];
          e.due = cyc + 1 + EC;
          sb.push_back(e);
          gl.push_back(c[0]);
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (rv[n]) begin
          if (!pv[n]) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_resp: resp%0d_valid high, none expected", n);
            end else begin
              e = sb[0];
              chk("resp_owner", n, e.ch);
              chk("resp_latency", cyc, e.due);
              chk("resp_out", ro[n], e.out);
              chk("resp_nzv", rn[n], e.nzv);
            end
          end else begin
            chk("resp_stable", {ro[n], rn[n]}, {po[n], pn[n]});
          end
          chk("nonowner_zero", {ro[1-n], rn[1-n], rv[1-n]}, 0);
          if (rr[n] && sb.size() > 0)
            void'(sb.pop_front());
        end
        pv[n] = rv[n];
        po[n] = ro[n];
        pn[n] = rn[n];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic logic [199:0] out_vec();
    return {req0_ready, req1_ready, resp0_valid, resp1_valid, busy,
            alu_op, alu_a, alu_b, resp0_out, resp0_nzv,
            resp1_out, resp1_nzv};
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    nrst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic wait_acc(input logic ch);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = ch ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    end
    chk("accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    chk("idle_timeout", ok, 1'b1);
  endtask

  task automatic drive(input vec_t v);
    exp_out[v.ch] = v.out;
    exp_nzv[v.ch] = v.nzv;
    if (!v.ch) begin
      req0_op = v.op; req0_a = v.a; req0_b = v.b;
      req0_valid = 1'b1;
    end else begin
      req1_op = v.op; req1_a = v.a; req1_b = v.b;
      req1_valid = 1'b1;
    end
  endtask

  // Drop the request and scramble operands so held values are exercised.
  task automatic release_req();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_op = 4'($urandom_range(0, 15));
    req1_op = 4'($urandom_range(0, 15));
    req0_a = $urandom; req0_b = $urandom;
    req1_a = $urandom; req1_b = $urandom;
  endtask

  initial begin
    vec_t v;
    bit   ok;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    exp_out[0] = '0; exp_out[1] = '0;
    exp_nzv[0] = '0; exp_nzv[1] = '0;

    vt[0] = '{1'b0, OP_ADD, 32'd5, 32'd7, 32'd12, 3'b000};
    vt[1] = '{1'b1, OP_SUB, 32'd3, 32'd3, 32'd0, 3'b010};
    vt[2] = '{1'b0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 3'b101};
    vt[3] = '{1'b1, OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 3'b100};
    vt[4] = '{1'b0, OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 3'b000};
    vt[5] = '{1'b1, OP_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 3'b010};
    vt[6] = '{1'b1, OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'd0, 3'b011};
    vt[7] = '{1'b0, OP_OR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 3'b000};
    vt[8] = '{1'b0, OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b001};

    #12;
    chk("reset_outputs_in_reset", out_vec(), 0);
    @(posedge clk); #1 nrst = 1'b1;
    @(negedge clk);
    chk("reset_outputs_after", out_vec(), 0);

    foreach (vt[i]) begin
      @(posedge clk); #1;
      drive(vt[i]);
      wait_acc(vt[i].ch);
      @(posedge clk); #1;
      release_req();
      wait_idle();
      chk($sformatf("vec%0d_drained", i), sb.size(), 0);
    end

    // Backpressure on channel 1.
    resp1_ready = 1'b0;
    @(posedge clk); #1;
    v = '{1'b1, OP_SUB, 32'd3, 32'd3, 32'd0, 3'b010};
    drive(v);
    wait_acc(1'b1);
    @(posedge clk); #1;
    release_req();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = resp1_valid;
    end
    chk("bp_resp_timeout", ok, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold", {busy, resp1_valid, resp1_out, resp1_nzv},
          {1'b1, 1'b1, 32'd0, 3'b010});
      @(negedge clk);
    end
    @(posedge clk); #1 resp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_busy_until_ready", busy, 1'b1);
    @(posedge clk); #1;
    chk("bp_released", {busy, resp1_valid}, 2'b00);

    // Asynchronous reset during the second EXEC cycle.
    @(posedge clk); #1;
    v = '{1'b0, OP_ADD, 32'd5, 32'd7, 32'd12, 3'b000};
    drive(v);
    wait_acc(1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_exec_busy", busy, 1'b1);
    req0_valid = 1'b0;
    #2 nrst = 1'b0;
    sb.delete();
    #1 chk("mid_exec_reset_outputs", out_vec(), 0);
    @(posedge clk); #1 nrst = 1'b1;
    for (int i = 0; i < EC + 3; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", {busy, resp0_valid, resp1_valid}, 0);
    end

    // Both requesters valid continuously from reset.
    apply_reset();
    gl.delete();
    seen_r1 = 1'b0;
    @(posedge clk); #1;
    exp_out[0] = 32'd3;  exp_nzv[0] = 3'b000;
    exp_out[1] = 32'd30; exp_nzv[1] = 3'b000;
    req0_op = OP_ADD; req0_a = 32'd1;  req0_b = 32'd2;
    req1_op = OP_ADD; req1_a = 32'd10; req1_b = 32'd20;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 100 && gl.size() < 4; i++)
      @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    chk("tie_count", gl.size(), 4);
    for (int i = 0; i < 4 && i < gl.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      chk($sformatf("tie_grant%0d", i), gl[i], i[0]);
`else
      chk($sformatf("tie_grant%0d", i), gl[i], 1'b0);
`endif
    end
`ifdef ALU_ARB_RR_EN
    chk("tie_req1_ready_seen", seen_r1, 1'b1);
`else
    chk("tie_req1_never_ready", seen_r1, 1'b0);
`endif
    chk("tie_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
